// File: rtl/sddr_pkg.sv
// Shared definitions for the DDR3 power-up/initialization sequencer.
package sddr_pkg;

  // Command encodings as {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP  = 3'b111;
  localparam logic [2:0] CMD_MRS  = 3'b000;
  localparam logic [2:0] CMD_ZQCL = 3'b110;

  // Address bit that selects "long" calibration on ZQ commands
  localparam int A10_BIT = 10;

  typedef enum logic [3:0] {
    ST_RESET_HOLD,
    ST_CKE_WAIT,
    ST_TXPR_WAIT,
    ST_MRS2,
    ST_MRS3,
    ST_MRS1,
    ST_MRS0,
    ST_MOD_WAIT,
    ST_ZQCL,
    ST_ZQ_WAIT,
    ST_DONE
  } sddr_init_state_t;

  function automatic int unsigned sddr_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sddr_init_sequencer.sv
// DDR3 power-up sequencer: reset hold, CKE wait, MR2/MR3/MR1/MR0, ZQCL, done.
// Outputs are registered decodes of the current state, so the pins lag the
// state register by one cycle; the reset state therefore already counts as
// the first RESET_HOLD cycle.
module sddr_init_sequencer
  import sddr_pkg::*;
#(
  parameter int unsigned BANK_BITS         = 3,
  parameter int unsigned ROW_BITS          = 13,
  parameter int unsigned RESET_HOLD_CYCLES = 40000,
  parameter int unsigned CKE_WAIT_CYCLES   = 100000,
  parameter int unsigned TXPR_CYCLES       = 72,
  parameter int unsigned TMRD_CYCLES       = 4,
  parameter int unsigned TMOD_CYCLES       = 12,
  parameter int unsigned TZQINIT_CYCLES    = 512,
  parameter logic [ROW_BITS-1:0] MR0_VALUE = '0,
  parameter logic [ROW_BITS-1:0] MR1_VALUE = '0,
  parameter logic [ROW_BITS-1:0] MR2_VALUE = '0,
  parameter logic [ROW_BITS-1:0] MR3_VALUE = '0
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_reset_i,
  output logic                 phy_clk_en_o,
  output logic                 ddr_reset_n_o,
  output logic                 cke_o,
  output logic                 ras_n_o,
  output logic                 cas_n_o,
  output logic                 we_n_o,
  output logic [BANK_BITS-1:0] ba_o,
  output logic [ROW_BITS-1:0]  addr_o,
  output logic                 odt_o,
  output logic                 init_done_o
);

  localparam int unsigned MAX_CYC = sddr_max(
      sddr_max(sddr_max(RESET_HOLD_CYCLES, CKE_WAIT_CYCLES), sddr_max(TXPR_CYCLES, TMRD_CYCLES)),
      sddr_max(TMOD_CYCLES, TZQINIT_CYCLES));
  localparam int CNT_W = $clog2(MAX_CYC) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter load values (N-1). MRS0 and ZQCL are single-cycle states whose
  // trailing NOPs live in MOD_WAIT / ZQ_WAIT, hence the N-2 loads there.
  localparam cnt_t LD_RH   = cnt_t'(RESET_HOLD_CYCLES - 1);
  localparam cnt_t LD_CKE  = cnt_t'(CKE_WAIT_CYCLES - 1);
  localparam cnt_t LD_TXPR = cnt_t'(TXPR_CYCLES - 1);
  localparam cnt_t LD_MRD  = cnt_t'(TMRD_CYCLES - 1);
  localparam cnt_t LD_MOD  = cnt_t'(TMOD_CYCLES - 2);
  localparam cnt_t LD_ZQ   = cnt_t'(TZQINIT_CYCLES - 2);

  localparam bit PARAMS_OK = (RESET_HOLD_CYCLES >= 1) && (CKE_WAIT_CYCLES >= 1) &&
                             (TXPR_CYCLES >= 1) && (TMRD_CYCLES >= 2) &&
                             (TMOD_CYCLES >= 2) && (TZQINIT_CYCLES >= 2) &&
                             (ROW_BITS > A10_BIT);

  sddr_init_state_t state_reg, state_next;
  cnt_t             cnt_reg, cnt_next;

  logic                 phy_clk_en_reg, phy_clk_en_next;
  logic                 reset_n_reg, reset_n_next;
  logic                 cke_reg, cke_next;
  logic [2:0]           cmd_reg, cmd_next;
  logic [BANK_BITS-1:0] ba_reg, ba_next;
  logic [ROW_BITS-1:0]  addr_reg, addr_next;
  logic                 done_reg, done_next;

  logic cnt_last;
  logic mrd_first;

  assign cnt_last  = (cnt_reg == '0);
  assign mrd_first = (cnt_reg == LD_MRD);

  // Next state, counter reload and pin decode of the current state
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg - cnt_t'(1);
    phy_clk_en_next = 1'b1;
    reset_n_next    = 1'b1;
    cke_next        = 1'b1;
    cmd_next        = CMD_NOP;
    ba_next         = '0;
    addr_next       = '0;
    done_next       = 1'b0;
    case (state_reg)
      ST_RESET_HOLD: begin
        reset_n_next = 1'b0;
        cke_next     = 1'b0;
        if (cnt_last) begin
          state_next = ST_CKE_WAIT;
          cnt_next   = LD_CKE;
        end
      end
      ST_CKE_WAIT: begin
        cke_next = 1'b0;
        if (cnt_last) begin
          state_next = ST_TXPR_WAIT;
          cnt_next   = LD_TXPR;
        end
      end
      ST_TXPR_WAIT: begin
        if (cnt_last) begin
          state_next = ST_MRS2;
          cnt_next   = LD_MRD;
        end
      end
      ST_MRS2: begin
        if (mrd_first) begin
          cmd_next  = CMD_MRS;
          ba_next   = BANK_BITS'(2);
          addr_next = MR2_VALUE;
        end
        if (cnt_last) begin
          state_next = ST_MRS3;
          cnt_next   = LD_MRD;
        end
      end
      ST_MRS3: begin
        if (mrd_first) begin
          cmd_next  = CMD_MRS;
          ba_next   = BANK_BITS'(3);
          addr_next = MR3_VALUE;
        end
        if (cnt_last) begin
          state_next = ST_MRS1;
          cnt_next   = LD_MRD;
        end
      end
      ST_MRS1: begin
        if (mrd_first) begin
          cmd_next  = CMD_MRS;
          ba_next   = BANK_BITS'(1);
          addr_next = MR1_VALUE;
        end
        if (cnt_last) begin
          state_next = ST_MRS0;
          cnt_next   = '0;
        end
      end
      ST_MRS0: begin
        cmd_next   = CMD_MRS;
        addr_next  = MR0_VALUE;
        state_next = ST_MOD_WAIT;
        cnt_next   = LD_MOD;
      end
      ST_MOD_WAIT: begin
        if (cnt_last) begin
          state_next = ST_ZQCL;
          cnt_next   = '0;
        end
      end
      ST_ZQCL: begin
        cmd_next           = CMD_ZQCL;
        addr_next[A10_BIT] = 1'b1;
        state_next         = ST_ZQ_WAIT;
        cnt_next           = LD_ZQ;
      end
      ST_ZQ_WAIT: begin
        if (cnt_last) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end
      end
      ST_DONE: begin
        done_next = 1'b1;
        cnt_next  = cnt_reg;
      end
      default: begin
        state_next = ST_RESET_HOLD;
        cnt_next   = LD_RH;
      end
    endcase
  end

  // State, shared counter and registered pins; reset restarts the sequence
  always_ff @(posedge in_ddr_clock_i or posedge in_reset_i) begin
    if (in_reset_i) begin
      state_reg      <= ST_RESET_HOLD;
      cnt_reg        <= LD_RH;
      phy_clk_en_reg <= 1'b0;
      reset_n_reg    <= 1'b0;
      cke_reg        <= 1'b0;
      cmd_reg        <= CMD_NOP;
      ba_reg         <= '0;
      addr_reg       <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      phy_clk_en_reg <= phy_clk_en_next;
      reset_n_reg    <= reset_n_next;
      cke_reg        <= cke_next;
      cmd_reg        <= cmd_next;
      ba_reg         <= ba_next;
      addr_reg       <= addr_next;
      done_reg       <= done_next;
    end
  end

  assign phy_clk_en_o  = phy_clk_en_reg;
  assign ddr_reset_n_o = reset_n_reg;
  assign cke_o         = cke_reg;
  assign ras_n_o       = cmd_reg[2];
  assign cas_n_o       = cmd_reg[1];
  assign we_n_o        = cmd_reg[0];
  assign ba_o          = ba_reg;
  assign addr_o        = addr_reg;
  assign odt_o         = 1'b0;
  assign init_done_o   = done_reg;

  // Timing parameters too small to leave a NOP between commands are rejected
  param_check: assert property (@(posedge in_ddr_clock_i) PARAMS_OK);

endmodule

// File: tb/tb_sddr_init_sequencer.sv
// Bench for sddr_init_sequencer: cycle-indexed event model plus literal pins.
module tb_sddr_init_sequencer;

  localparam int R = 4, C = 6, X = 3, D = 4, M = 12, Z = 8;
  localparam int T0 = R + C + X;

  typedef struct packed {
    logic        phy;
    logic        rstn;
    logic        cke;
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] addr;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        phy_clk_en, ddr_reset_n, cke, ras_n, cas_n, we_n, odt, init_done;
  logic [2:0]  ba;
  logic [12:0] addr;

  int k = -1;
  int total = 0;
  int bad = 0;
  int cmd_cnt = 0;

  sddr_init_sequencer #(
    .BANK_BITS(3), .ROW_BITS(13),
    .RESET_HOLD_CYCLES(R), .CKE_WAIT_CYCLES(C), .TXPR_CYCLES(X),
    .TMRD_CYCLES(D), .TMOD_CYCLES(M), .TZQINIT_CYCLES(Z),
    .MR0_VALUE(13'h0120), .MR1_VALUE(13'h0044),
    .MR2_VALUE(13'h0008), .MR3_VALUE(13'h0000)
  ) dut (
    .in_ddr_clock_i(clk),
    .in_reset_i(rst),
    .phy_clk_en_o(phy_clk_en),
    .ddr_reset_n_o(ddr_reset_n),
    .cke_o(cke),
    .ras_n_o(ras_n),
    .cas_n_o(cas_n),
    .we_n_o(we_n),
    .ba_o(ba),
    .addr_o(addr),
    .odt_o(odt),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  // Cycle index: 0 at the first rising edge after reset release, -1 in reset
  always @(posedge clk or posedge rst) begin
    if (rst) k <= -1;
    else     k <= k + 1;
  end

  // Expected pins at cycle k, derived from the event times of the sequence
  function automatic exp_t model(input int kk);
    exp_t        m;
    int          t_cmd [4];
    int          bank_ord [4];
    logic [12:0] mr_val [4];
    t_cmd    = '{T0, T0 + D, T0 + 2 * D, T0 + 3 * D};
    bank_ord = '{2, 3, 1, 0};
    mr_val   = '{13'h0120, 13'h0044, 13'h0008, 13'h0000};
    m     = '0;
    m.cmd = 3'b111;
    if (kk < 0) return m;
    m.phy  = 1'b1;
    m.rstn = (kk >= R);
    m.cke  = (kk >= R + C);
    for (int i = 0; i < 4; i++) begin
      if (kk == t_cmd[i]) begin
        m.cmd  = 3'b000;
        m.ba   = 3'(bank_ord[i]);
        m.addr = mr_val[bank_ord[i]];
      end
    end
    if (kk == T0 + 3 * D + M) begin
      m.cmd  = 3'b110;
      m.addr = 13'h0400;
    end
    m.done = (kk >= T0 + 3 * D + M + Z);
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s k=%0d actual=%0h required=%0h", nm, k, act, req);
    end
  endtask

  // Per-cycle comparison against the model
  exp_t e;
  always @(negedge clk) begin
    e = model(k);
    chk("phy_clk_en", 32'(phy_clk_en), 32'(e.phy));
    chk("ddr_reset_n", 32'(ddr_reset_n), 32'(e.rstn));
    chk("cke", 32'(cke), 32'(e.cke));
    chk("cmd", 32'({ras_n, cas_n, we_n}), 32'(e.cmd));
    chk("ba", 32'(ba), 32'(e.ba));
    chk("addr", 32'(addr), 32'(e.addr));
    chk("init_done", 32'(init_done), 32'(e.done));
    chk("odt", 32'(odt), 32'd0);
    if ({ras_n, cas_n, we_n} != 3'b111) cmd_cnt++;
  end

  task automatic wait_k(input int n);
    for (int i = 0; i < 400 && k != n; i++) @(negedge clk);
    chk("wait_cycle", 32'(k), 32'(n));
  endtask

  initial begin
    #1 rst = 1'b1;
    // Long reset: the per-cycle checker expects reset values throughout
    repeat (50) @(negedge clk);
    rst = 1'b0;
    cmd_cnt = 0;

    wait_k(3);   chk("rstn_c3", 32'(ddr_reset_n), 32'd0);
    wait_k(4);   chk("rstn_c4", 32'(ddr_reset_n), 32'd1);
    wait_k(9);   chk("cke_c9", 32'(cke), 32'd0);
    wait_k(10);  chk("cke_c10", 32'(cke), 32'd1);
    wait_k(13);
    chk("mr2_cmd", 32'({ras_n, cas_n, we_n}), 32'h0);
    chk("mr2_ba", 32'(ba), 32'd2);
    chk("mr2_addr", 32'(addr), 32'h0008);
    wait_k(21);  chk("mr1_addr", 32'(addr), 32'h0044);
    wait_k(25);  chk("mr0_addr", 32'(addr), 32'h0120);
    wait_k(37);
    chk("zq_cmd", 32'({ras_n, cas_n, we_n}), 32'h6);
    chk("zq_addr", 32'(addr), 32'h0400);
    wait_k(44);  chk("done_c44", 32'(init_done), 32'd0);
    wait_k(45);  chk("done_c45", 32'(init_done), 32'd1);
    wait_k(145); chk("done_c145", 32'(init_done), 32'd1);
    chk("cmd_count_1", 32'(cmd_cnt), 32'd5);

    // Restart, then reset in the middle of the MRS phase
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_k(22);
    #2 rst = 1'b1;
    #1;
    chk("async_phy", 32'(phy_clk_en), 32'd0);
    chk("async_rstn", 32'(ddr_reset_n), 32'd0);
    chk("async_cke", 32'(cke), 32'd0);
    chk("async_cmd", 32'({ras_n, cas_n, we_n}), 32'h7);
    chk("async_addr", 32'(addr), 32'h0);
    chk("async_done", 32'(init_done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmd_cnt = 0;
    wait_k(12);  chk("re_c12_cmd", 32'({ras_n, cas_n, we_n}), 32'h7);
    wait_k(13);
    chk("re_mr2_cmd", 32'({ras_n, cas_n, we_n}), 32'h0);
    chk("re_mr2_ba", 32'(ba), 32'd2);
    wait_k(60);
    chk("cmd_count_2", 32'(cmd_cnt), 32'd5);
    chk("done_c60", 32'(init_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
